// File: rtl/pipe_drawer_if.sv
// Handshake between game-state logic (master) and the lower-pipe outline drawer (slave).
interface pipe_drawer_if;
    logic        enable;
    logic [10:0] pipe_x;
    logic [10:0] pipe_y;
    logic [10:0] x;
    logic [10:0] y;
    logic        plot;
    logic        done;

    modport master (output enable, pipe_x, pipe_y, input x, y, plot, done);
    modport slave  (input enable, pipe_x, pipe_y, output x, y, plot, done);
endinterface

// File: rtl/pipe_drawer.sv
// Traces the beveled outline of the lower pipe, one registered pixel per clock.
// Define PIPE_DRAWER_CLIP_EN to suppress plot for off-screen pixels.
module pipe_drawer #(
    parameter int PIPE_W   = 60,
    parameter int BEVEL    = 10,
    parameter int GAP      = 100,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input logic          clk,
    input logic          reset,
    pipe_drawer_if.slave bus
);

    typedef logic signed [11:0] coord_t;
    typedef enum logic [2:0] {
        StIdle, StLine1, StLine2, StLine3, StLine4, StLine5, StLine6, StLine7
    } state_e;

    localparam coord_t PipeW   = coord_t'(PIPE_W);
    localparam coord_t Bevel   = coord_t'(BEVEL);
    localparam coord_t Gap     = coord_t'(GAP);
    localparam coord_t ScreenH = coord_t'(SCREEN_H);
`ifdef PIPE_DRAWER_CLIP_EN
    localparam coord_t ScreenW = coord_t'(SCREEN_W);
`endif

    function automatic coord_t seg_len(input state_e s, input coord_t c);
        coord_t len;
        len = 12'sd0;
        case (s)
            StLine1: len = ScreenH - 12'sd1 - c;
            StLine2, StLine3, StLine5, StLine6: len = Bevel;
            StLine4: len = PipeW + Bevel + Bevel;
            StLine7: len = ScreenH - c;
            default: len = 12'sd0;
        endcase
        return len;
    endfunction

    // First segment at or after index 'from' with a positive length; empty ones cost no cycle.
    function automatic state_e next_seg(input int from, input coord_t c);
        state_e r;
        r = StIdle;
        for (int i = 7; i >= 1; i--) begin
            if (i >= from && seg_len(state_e'(3'(i)), c) > 12'sd0) r = state_e'(3'(i));
        end
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [10:0] px_q, px_d;
    logic [10:0] py_q, py_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        plot_q, plot_d;
    logic        done_q, done_d;

    coord_t c_q, c_start;
    coord_t l_n, r_n, t_n, c_n, cnt_n, xs, ys, len_n;

    assign c_q     = $signed({1'b0, py_q}) + Gap + Bevel;
    assign c_start = $signed({1'b0, bus.pipe_y}) + Gap + Bevel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            plot_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            px_q    <= px_d;
            py_q    <= py_d;
            x_q     <= x_d;
            y_q     <= y_d;
            plot_q  <= plot_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 12'd1;
        px_d    = px_q;
        py_d    = py_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
            if (bus.enable) begin
                px_d    = bus.pipe_x;
                py_d    = bus.pipe_y;
                state_d = next_seg(1, c_start);
            end
        end else if (cnt_q == $unsigned(seg_len(state_q, c_q) - 12'sd1)) begin
            state_d = next_seg(int'(state_q) + 1, c_q);
            cnt_d   = '0;
        end
    end

    // Outputs are derived from next-state values so they land in the same cycle as the state.
    always_comb begin
        l_n   = $signed({1'b0, px_d}) - PipeW;
        r_n   = $signed({1'b0, px_d}) + Bevel;
        t_n   = $signed({1'b0, py_d}) + Gap;
        c_n   = t_n + Bevel;
        cnt_n = $signed(cnt_d);
        xs    = 12'sd0;
        ys    = 12'sd0;
        case (state_d)
            StLine1: begin xs = l_n;         ys = ScreenH - 12'sd1 - cnt_n; end
            StLine2: begin xs = l_n - cnt_n; ys = c_n;                      end
            StLine3: begin xs = l_n - Bevel; ys = c_n - cnt_n;              end
            StLine4: begin xs = l_n - Bevel + cnt_n; ys = t_n;              end
            StLine5: begin xs = r_n;         ys = t_n + cnt_n;              end
            StLine6: begin xs = r_n - cnt_n; ys = c_n;                      end
            StLine7: begin xs = r_n - Bevel; ys = c_n + cnt_n;              end
            default: begin xs = 12'sd0;      ys = 12'sd0;                   end
        endcase
        len_n  = seg_len(state_d, c_n);
        x_d    = xs[10:0];
        y_d    = ys[10:0];
`ifdef PIPE_DRAWER_CLIP_EN
        plot_d = (state_d != StIdle) && (xs >= 12'sd0) && (xs < ScreenW)
                 && (ys >= 12'sd0) && (ys < ScreenH);
`else
        plot_d = (state_d != StIdle);
`endif
        done_d = (state_d != StIdle) && (cnt_d == $unsigned(len_n - 12'sd1))
                 && (next_seg(int'(state_d) + 1, c_n) == StIdle);
    end

    assign bus.x    = x_q;
    assign bus.y    = y_q;
    assign bus.plot = plot_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_pipe_drawer.sv
// Self-checking bench for pipe_drawer against a segment-list reference model.
module tb_pipe_drawer;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   exp_x[$];
    int   exp_y[$];

    pipe_drawer_if bus ();

    pipe_drawer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Outline as a plain list of points, segment by segment from the geometric description.
    task automatic build_model(input int px, input int py);
        int l, r, t, c;
        l = px - 60;
        r = px + 10;
        t = py + 100;
        c = t + 10;
        exp_x.delete();
        exp_y.delete();
        for (int y = 479; y > c; y--)      begin exp_x.push_back(l);      exp_y.push_back(y); end
        for (int x = l; x > l - 10; x--)   begin exp_x.push_back(x);      exp_y.push_back(c); end
        for (int y = c; y > t; y--)        begin exp_x.push_back(l - 10); exp_y.push_back(y); end
        for (int x = l - 10; x < r; x++)   begin exp_x.push_back(x);      exp_y.push_back(t); end
        for (int y = t; y < c; y++)        begin exp_x.push_back(r);      exp_y.push_back(y); end
        for (int x = r; x > r - 10; x--)   begin exp_x.push_back(x);      exp_y.push_back(c); end
        for (int y = c; y < 480; y++)      begin exp_x.push_back(r - 10); exp_y.push_back(y); end
    endtask

    function automatic logic exp_plot(input int x, input int y);
`ifdef PIPE_DRAWER_CLIP_EN
        return (x >= 0 && x < 640 && y >= 0 && y < 480);
`else
        return 1'b1;
`endif
    endfunction

    task automatic start_draw(input int px, input int py);
        @(negedge clk);
        bus.pipe_x = 11'(px);
        bus.pipe_y = 11'(py);
        bus.enable = 1'b1;
    endtask

    // Walks the model list, one pixel per cycle, then expects one idle cycle.
    task automatic check_draw(input string name, input bit hold, input int nx, input int ny);
        int n;
        logic [23:0] act, req;
        n = exp_x.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            act = {bus.x, bus.y, bus.plot, bus.done};
            req = {11'(exp_x[i]), 11'(exp_y[i]), exp_plot(exp_x[i], exp_y[i]), (i == n - 1)};
            tests++;
            if (act !== req) begin
                fails++;
                $display("FAIL %s pix%0d: got x=%0d y=%0d plot=%b done=%b, want x=%0d y=%0d plot=%b done=%b",
                         name, i, act[23:13], act[12:2], act[1], act[0],
                         req[23:13], req[12:2], req[1], req[0]);
            end
            if (i == 0) begin
                bus.pipe_x = 11'(nx);
                bus.pipe_y = 11'(ny);
                if (!hold) bus.enable = 1'b0;
            end
        end
        @(negedge clk);
        tests++;
        if ({bus.x, bus.y, bus.plot, bus.done} !== 24'd0) begin
            fails++;
            $display("FAIL %s idle: got x=%0d y=%0d plot=%b done=%b, want all zero",
                     name, bus.x, bus.y, bus.plot, bus.done);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bus.enable = 1'b1;
        bus.pipe_x = 11'd200;
        bus.pipe_y = 11'd200;
        repeat (2) begin
            @(negedge clk);
            tests++;
            if ({bus.x, bus.y, bus.plot, bus.done} !== 24'd0) begin
                fails++;
                $display("FAIL reset: got x=%0d y=%0d plot=%b done=%b, want all zero",
                         bus.x, bus.y, bus.plot, bus.done);
            end
        end
        bus.enable = 1'b0;
        reset      = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.plot !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got plot=%b, want 0", bus.plot);
        end
    endtask

    task automatic test_draw(input string name, input int px, input int py);
        build_model(px, py);
        start_draw(px, py);
        check_draw(name, 1'b0, $urandom_range(0, 2047), $urandom_range(0, 2047));
    endtask

    task automatic test_random();
        int px, py;
        for (int k = 0; k < 6; k++) begin
            px = $urandom_range(0, 700);
            py = $urandom_range(0, 450);
            test_draw("random", px, py);
        end
    endtask

    task automatic test_back_to_back();
        build_model(200, 200);
        start_draw(200, 200);
        check_draw("b2b_first", 1'b1, 300, 120);
        build_model(300, 120);
        check_draw("b2b_second", 1'b0, 10, 10);
    endtask

    task automatic test_abort();
        int done_seen;
        done_seen = 0;
        build_model(200, 200);
        start_draw(200, 200);
        for (int i = 0; i < 195; i++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
            if (i == 0) bus.enable = 1'b0;
        end
        tests++;
        if (bus.x !== 11'(exp_x[194]) || bus.y !== 11'(exp_y[194])) begin
            fails++;
            $display("FAIL abort_pos: got x=%0d y=%0d, want x=%0d y=%0d",
                     bus.x, bus.y, exp_x[194], exp_y[194]);
        end
        reset = 1'b1;
        @(negedge clk);
        if (bus.done) done_seen++;
        tests++;
        if ({bus.x, bus.y, bus.plot, bus.done} !== 24'd0 || done_seen != 0) begin
            fails++;
            $display("FAIL abort: got x=%0d y=%0d plot=%b done=%b dones=%0d, want all zero",
                     bus.x, bus.y, bus.plot, bus.done, done_seen);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_draw("nominal", 200, 200);
        test_draw("skipped", 50, 380);
        test_draw("left_edge", 40, 200);
        test_draw("right_edge", 650, 50);
        test_random();
        test_back_to_back();
        test_abort();
        test_draw("after_abort", 320, 150);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
